// File: rtl/seq_checker_lock.sv
`default_nettype none
// ============================================================================
// Module   : seq_checker_lock
// Purpose  : Serial frame synchroniser/checker. Hunts bit-by-bit for a 6-bit
//            PATTERN on a qualified serial stream. It confirms alignment over
//            LOCK_CNT consecutive frames, then reports LOCKED. LOCKED is
//            released after UNLOCK_CNT consecutive bad frames. While locked,
//            it counts good frames, bad frames and mismatching bits.
// Ports    : clk           - clock, rising edge
//            rst_n         - asynchronous active-low reset
//            i_din         - serial data bit (MSB of frame first)
//            i_din_vld     - qualifier for i_din
//            i_clr         - synchronous clear of the statistics counters
//            o_locked      - high while in LOCKED
//            o_match_p     - 1-cycle pulse per good frame checked (SYNC/LOCKED)
//            o_err_p       - 1-cycle pulse per bad frame checked (SYNC/LOCKED)
//            o_frame_cnt   - good frames checked in LOCKED (saturating)
//            o_err_cnt     - bad frames checked in LOCKED (saturating)
//            o_bit_err_cnt - mismatching bits in LOCKED bad frames (clamping)
// Revision : 1.0 - initial release
// ============================================================================
module seq_checker_lock #(
  parameter logic [5:0] PATTERN    = 6'b001011,
  parameter int         LOCK_CNT   = 3,
  parameter int         UNLOCK_CNT = 2,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_din,
  input  logic             i_din_vld,
  input  logic             i_clr,
  output logic             o_locked,
  output logic             o_match_p,
  output logic             o_err_p,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_bit_err_cnt
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

  localparam logic [GOOD_W-1:0] c_LOCK_GOOD   = GOOD_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] c_UNLOCK_MISS = MISS_W'(UNLOCK_CNT);
  localparam logic [CNT_W-1:0]  c_CNT_MAX     = '1;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t              r_state;
  // The oldest bit of the 6-bit window drops out on every shift. Only the five
  // newest bits must be stored; w_win_next is always the full 6-bit window.
  logic [4:0]          r_win_hist;
  logic [2:0]          r_fill;
  logic [2:0]          r_phase;
  logic [GOOD_W-1:0]   r_good;
  logic [MISS_W-1:0]   r_miss;
  logic                r_locked;
  logic                r_match_p;
  logic                r_err_p;
  logic [CNT_W-1:0]    r_frame_cnt;
  logic [CNT_W-1:0]    r_err_cnt;
  logic [CNT_W-1:0]    r_bit_err_cnt;

  logic [5:0]          w_win_next;
  logic [5:0]          w_diff;
  logic [2:0]          w_pop;
  logic                w_is_match;
  logic                w_fill_full;
  logic                w_chk_pt;
  logic [GOOD_W-1:0]   w_good_inc;
  logic [MISS_W-1:0]   w_miss_inc;
  logic [CNT_W:0]      w_bit_err_sum;

  assign w_win_next  = {r_win_hist, i_din};
  assign w_diff      = w_win_next ^ PATTERN;
  assign w_is_match  = (w_diff == 6'd0);
  // Fill becomes 6 on this valid bit (or already is 6).
  assign w_fill_full = (r_fill >= 3'd5);
  // The valid bit that wraps phase 5 -> 0 is the frame check point.
  assign w_chk_pt    = (r_phase == 3'd5);
  assign w_good_inc  = r_good + GOOD_W'(1);
  assign w_miss_inc  = r_miss + MISS_W'(1);

  always_comb begin
    w_pop = 3'd0;
    for (int i = 0; i < 6; i++) begin
      w_pop = w_pop + {2'b00, w_diff[i]};
    end
  end

  // One extra bit lets the accumulation detect overflow, so it can clamp.
  assign w_bit_err_sum = {1'b0, r_bit_err_cnt} + (CNT_W + 1)'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_HUNT;
      r_win_hist    <= '0;
      r_fill        <= '0;
      r_phase       <= '0;
      r_good        <= '0;
      r_miss        <= '0;
      r_locked      <= 1'b0;
      r_match_p     <= 1'b0;
      r_err_p       <= 1'b0;
      r_frame_cnt   <= '0;
      r_err_cnt     <= '0;
      r_bit_err_cnt <= '0;
    end else begin
      r_match_p <= 1'b0;
      r_err_p   <= 1'b0;

      if (i_din_vld) begin
        r_win_hist <= w_win_next[4:0];
        if (r_fill != 3'd6) begin
          r_fill <= r_fill + 3'd1;
        end

        case (r_state)
          ST_HUNT: begin
            if (w_fill_full && w_is_match) begin
              r_phase  <= 3'd0;
              r_good   <= GOOD_W'(1);
              r_miss   <= '0;
              r_state  <= (LOCK_CNT == 1) ? ST_LOCKED : ST_SYNC;
              r_locked <= (LOCK_CNT == 1);
            end
          end

          ST_SYNC: begin
            if (w_chk_pt) begin
              r_phase <= 3'd0;
              if (w_is_match) begin
                r_match_p <= 1'b1;
                r_good    <= w_good_inc;
                if (w_good_inc == c_LOCK_GOOD) begin
                  r_state  <= ST_LOCKED;
                  r_locked <= 1'b1;
                  r_miss   <= '0;
                end
              end else begin
                r_err_p <= 1'b1;
                r_good  <= '0;
                r_state <= ST_HUNT;
              end
            end else begin
              r_phase <= r_phase + 3'd1;
            end
          end

          ST_LOCKED: begin
            if (w_chk_pt) begin
              r_phase <= 3'd0;
              if (w_is_match) begin
                r_match_p <= 1'b1;
                r_miss    <= '0;
                if (r_frame_cnt != c_CNT_MAX) begin
                  r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                end
              end else begin
                r_err_p <= 1'b1;
                if (r_err_cnt != c_CNT_MAX) begin
                  r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
                r_bit_err_cnt <= w_bit_err_sum[CNT_W] ? c_CNT_MAX
                                                      : w_bit_err_sum[CNT_W-1:0];
                if (w_miss_inc == c_UNLOCK_MISS) begin
                  r_state  <= ST_HUNT;
                  r_locked <= 1'b0;
                  r_miss   <= '0;
                  r_good   <= '0;
                end else begin
                  r_miss <= w_miss_inc;
                end
              end
            end else begin
              r_phase <= r_phase + 3'd1;
            end
          end

          default: begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end

      // Clear wins over any same-cycle counter update (later NBA takes effect).
      if (i_clr) begin
        r_frame_cnt   <= '0;
        r_err_cnt     <= '0;
        r_bit_err_cnt <= '0;
      end
    end
  end

  assign o_locked      = r_locked;
  assign o_match_p     = r_match_p;
  assign o_err_p       = r_err_p;
  assign o_frame_cnt   = r_frame_cnt;
  assign o_err_cnt     = r_err_cnt;
  assign o_bit_err_cnt = r_bit_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_checker_lock.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_checker_lock
// Purpose  : Directed self-checking bench for seq_checker_lock. Counters are
//            4 bits wide so saturation is reachable in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_checker_lock;

  localparam int         CNT_W = 4;
  localparam logic [5:0] PAT   = 6'b001011;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_din = 1'b0;
  logic             i_din_vld = 1'b0;
  logic             i_clr = 1'b0;
  logic             o_locked;
  logic             o_match_p;
  logic             o_err_p;
  logic [CNT_W-1:0] o_frame_cnt;
  logic [CNT_W-1:0] o_err_cnt;
  logic [CNT_W-1:0] o_bit_err_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [5:0] r_pat = PAT;

  seq_checker_lock #(
    .PATTERN   (PAT),
    .LOCK_CNT  (3),
    .UNLOCK_CNT(2),
    .CNT_W     (CNT_W)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_din        (i_din),
    .i_din_vld    (i_din_vld),
    .i_clr        (i_clr),
    .o_locked     (o_locked),
    .o_match_p    (o_match_p),
    .o_err_p      (o_err_p),
    .o_frame_cnt  (o_frame_cnt),
    .o_err_cnt    (o_err_cnt),
    .o_bit_err_cnt(o_bit_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic tick(input logic b, input logic v, input logic c);
    i_din     = b;
    i_din_vld = v;
    i_clr     = c;
    @(posedge clk);
    #1;
    i_din_vld = 1'b0;
    i_clr     = 1'b0;
  endtask

  task automatic send_frame(input logic [5:0] f);
    for (int i = 5; i >= 0; i--) tick(f[i], 1'b1, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".locked"}, o_locked, 0);
    chk({tag, ".match_p"}, o_match_p, 0);
    chk({tag, ".err_p"}, o_err_p, 0);
    chk({tag, ".frame_cnt"}, o_frame_cnt, 0);
    chk({tag, ".err_cnt"}, o_err_cnt, 0);
    chk({tag, ".bit_err_cnt"}, o_bit_err_cnt, 0);
  endtask

  task automatic do_reset();
    i_din_vld = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_all_zero("rst");

    // Continuous pattern stream: hunt at 6, match at 12/18, lock after 18.
    for (int k = 1; k <= 42; k++) begin
      tick(r_pat[5 - ((k - 1) % 6)], 1'b1, 1'b0);
      chk($sformatf("A.match_p@%0d", k), o_match_p, (k % 6 == 0 && k >= 12));
      chk($sformatf("A.err_p@%0d", k), o_err_p, 0);
      chk($sformatf("A.locked@%0d", k), o_locked, (k >= 18));
    end
    chk("A.frame_cnt", o_frame_cnt, 4);
    chk("A.err_cnt", o_err_cnt, 0);

    // Single-bit error frame while locked
    send_frame(6'b101011);
    chk("B.err_p", o_err_p, 1);
    chk("B.match_p", o_match_p, 0);
    chk("B.err_cnt", o_err_cnt, 1);
    chk("B.bit_err_cnt", o_bit_err_cnt, 1);
    chk("B.locked", o_locked, 1);
    tick(1'b0, 1'b0, 1'b0);
    chk("B.err_p_one_cycle", o_err_p, 0);
    send_frame(PAT);
    chk("B.match_p2", o_match_p, 1);
    chk("B.frame_cnt", o_frame_cnt, 5);
    // A second isolated error must not unlock: the good frame cleared miss.
    send_frame(6'b101011);
    chk("B.err_cnt2", o_err_cnt, 2);
    chk("B.bit_err_cnt2", o_bit_err_cnt, 2);
    chk("B.locked2", o_locked, 1);

    // Two consecutive fully-inverted frames unlock, then relock
    do_reset();
    chk_all_zero("C.rst");
    for (int k = 1; k <= 18; k++) tick(r_pat[5 - ((k - 1) % 6)], 1'b1, 1'b0);
    chk("C.locked0", o_locked, 1);
    send_frame(6'b110100);
    chk("C.err_p1", o_err_p, 1);
    chk("C.locked1", o_locked, 1);
    chk("C.bit_err_cnt1", o_bit_err_cnt, 6);
    send_frame(6'b110100);
    chk("C.err_p2", o_err_p, 1);
    chk("C.err_cnt", o_err_cnt, 2);
    chk("C.bit_err_cnt", o_bit_err_cnt, 12);
    chk("C.locked2", o_locked, 0);
    send_frame(PAT);
    chk("C.hunt_no_match_p", o_match_p, 0);
    chk("C.hunt_no_err_p", o_err_p, 0);
    chk("C.relock_a", o_locked, 0);
    send_frame(PAT);
    chk("C.sync_match_p", o_match_p, 1);
    chk("C.relock_b", o_locked, 0);
    send_frame(PAT);
    chk("C.sync_match_p2", o_match_p, 1);
    chk("C.relock_c", o_locked, 1);
    chk("C.frame_cnt", o_frame_cnt, 0);
    chk("C.err_cnt_hold", o_err_cnt, 2);

    // din_vld toggling: invalid cycles carry inverted data and must be ignored
    do_reset();
    for (int k = 1; k <= 42; k++) begin
      tick(r_pat[5 - ((k - 1) % 6)], 1'b1, 1'b0);
      chk($sformatf("D.match_p@%0d", k), o_match_p, (k % 6 == 0 && k >= 12));
      chk($sformatf("D.locked@%0d", k), o_locked, (k >= 18));
      tick(~r_pat[5 - ((k - 1) % 6)], 1'b0, 1'b0);
      chk($sformatf("D.gap_match_p@%0d", k), o_match_p, 0);
      chk($sformatf("D.gap_err_p@%0d", k), o_err_p, 0);
    end
    chk("D.frame_cnt", o_frame_cnt, 4);
    chk("D.err_cnt", o_err_cnt, 0);

    // clr on the same edge as a locked good check
    for (int i = 5; i >= 1; i--) tick(r_pat[i], 1'b1, 1'b0);
    tick(r_pat[0], 1'b1, 1'b1);
    chk("E.clr_frame_cnt", o_frame_cnt, 0);
    chk("E.clr_match_p", o_match_p, 1);
    chk("E.clr_locked", o_locked, 1);

    // Alternate bad/good frames: stays locked, counters saturate/clamp at 15
    for (int r = 1; r <= 16; r++) begin
      send_frame(6'b110100);
      chk($sformatf("E.err_cnt@%0d", r), o_err_cnt, (r < 15) ? r : 15);
      chk($sformatf("E.bit_err_cnt@%0d", r), o_bit_err_cnt, (6 * r < 15) ? 6 * r : 15);
      send_frame(PAT);
      chk($sformatf("E.frame_cnt@%0d", r), o_frame_cnt, (r < 15) ? r : 15);
      chk($sformatf("E.locked@%0d", r), o_locked, 1);
    end
    tick(1'b0, 1'b0, 1'b1);
    chk("E.idle_clr_err", o_err_cnt, 0);
    chk("E.idle_clr_bit", o_bit_err_cnt, 0);
    chk("E.idle_clr_frame", o_frame_cnt, 0);
    chk("E.idle_clr_locked", o_locked, 1);

    // Asynchronous reset mid-frame while locked
    for (int i = 5; i >= 3; i--) tick(r_pat[i], 1'b1, 1'b0);
    send_frame(PAT);
    chk("F.pre_locked", o_locked, 1);
    tick(r_pat[5], 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("F.async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick(r_pat[5 - ((k - 1) % 6)], 1'b1, 1'b0);
      chk($sformatf("F.locked@%0d", k), o_locked, (k >= 18));
    end
    chk("F.frame_cnt", o_frame_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_checker_lock.md
SEQ_CHECKER_LOCK -- requirements
Module: seq_checker_lock

Interface
REQ-001 SHALL have parameter PATTERN, default 6'b001011, the 6-bit frame expected MSB-first on din.
REQ-002 SHALL have parameter LOCK_CNT, default 3, the number of consecutive good frames (including the hunt hit) needed to reach LOCKED.
REQ-003 SHALL have parameter UNLOCK_CNT, default 2, the number of consecutive bad frames in LOCKED that force a return to HUNT.
REQ-004 SHALL have parameter CNT_W, default 16, the width of the statistics counters.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 din  input  1  serial data bit.
REQ-008 din_vld  input  1  din qualifier; clock edges with din_vld=0 SHALL change nothing except clr effects and pulse clearing.
REQ-009 clr  input  1  synchronous clear of the statistics counters.
REQ-010 locked  output  1  high while the state is LOCKED.
REQ-011 match_p  output  1  one-cycle pulse for each good frame checked in SYNC or LOCKED.
REQ-012 err_p  output  1  one-cycle pulse for each bad frame checked in SYNC or LOCKED.
REQ-013 frame_cnt  output  CNT_W  count of good frames checked in LOCKED.
REQ-014 err_cnt  output  CNT_W  count of bad frames checked in LOCKED.
REQ-015 bit_err_cnt  output  CNT_W  total of mismatching bits in bad frames checked in LOCKED.

Function
REQ-016 The window SHALL be a 6-bit shift register; on every valid bit, win_next = {win[4:0], din}, and all compares SHALL use win_next.
REQ-017 The fill counter SHALL count valid bits and saturate at 6; it SHALL be cleared only by reset.
REQ-018 In HUNT, when fill reaches 6 and win_next==PATTERN, the block SHALL move to SYNC with phase=0 and good=1; if LOCK_CNT==1, it SHALL go directly to LOCKED instead.
REQ-019 In SYNC and LOCKED, phase SHALL count valid bits 0..5; the bit that wraps phase from 5 to 0 is the frame check point (6 valid bits after the previous check).
REQ-020 SYNC frame check: on match, good SHALL increment and the state SHALL go to LOCKED when good reaches LOCK_CNT; on mismatch, the state SHALL go to HUNT and good SHALL clear.
REQ-021 LOCKED frame check, match: frame_cnt SHALL increment and miss SHALL clear.
REQ-022 LOCKED frame check, mismatch: err_cnt SHALL increment, bit_err_cnt SHALL add popcount(win_next^PATTERN), and miss SHALL increment; when miss reaches UNLOCK_CNT, the state SHALL go to HUNT and miss SHALL clear.
REQ-023 On entry to HUNT, the window SHALL be retained so that realignment can occur on the very next valid bit.
REQ-024 match_p and err_p SHALL be registered, asserted in the cycle after the check-point edge, and high for exactly one cycle.
REQ-025 locked SHALL be registered and change in the cycle after the deciding check.
REQ-026 All counters SHALL saturate at all-ones; a bit_err_cnt addition SHALL clamp at all-ones.
REQ-027 If clr and a counter update occur in the same cycle, clr SHALL win and the counter SHALL read 0; clr SHALL NOT affect state, window, fill, phase, good, or miss.
REQ-028 No frame checks SHALL occur in HUNT, so HUNT SHALL generate no match_p or err_p.

Reset
REQ-029 On rst_n=0, at any time including mid-frame, the block SHALL go to HUNT with win=0, fill=0, phase=0, good=0, miss=0, all counters=0, and locked=match_p=err_p=0.
REQ-030 After rst_n deasserts, the first valid bit SHALL be treated as bit 1 of a fresh fill.

Verification
REQ-031 Continuous 001011 stream with din_vld=1 -> HUNT hit at bit 6, match_p after bits 12 and 18, locked=1 the cycle after bit 18; frame_cnt=4 after bit 42.
REQ-032 Locked stream, one frame sent as 101011 -> err_p once, err_cnt=1, bit_err_cnt=1, locked stays 1; the next good frame clears miss.
REQ-033 Locked stream, two consecutive frames of 110100 -> err_cnt=2, bit_err_cnt=12, locked=0 after the second; a clean stream relocks after LOCK_CNT frames.
REQ-034 Locked stream with din_vld toggling 1010... -> identical counts as REQ-031 per valid bit; no checks occur on invalid cycles.
REQ-035 clr asserted on the same edge as a LOCKED good check -> frame_cnt=0 and locked unchanged; err_cnt forced to 2^CNT_W-1 by errors stays saturated.
REQ-036 rst_n pulsed low mid-frame while locked -> all outputs 0 immediately; relock only after 6+12 further valid pattern bits.
